// File: rtl/arm_pkg.sv
// Shared types and constants for the ARM fetch front end.
package arm_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } fetch_state_e;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with redirect (highest priority) and sequential increment.
module fetch_pc_reg
    import arm_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] PC_STEP  = 32'd4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next
);

    always_comb begin
        pc_next = pc;
        if (redirect) begin
            pc_next = word_align(redirect_addr);
        end else if (inc) begin
            pc_next = pc + PC_STEP;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch front end: PC ownership, imem req/ack handshake, branch kill, freeze hold.
// Optional stall counter enabled by defining FETCH_PERF_CNT_EN.
module if_fetch_unit
    import arm_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] PC_STEP  = 32'd4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [INSTR_W-1:0] instruction_out,
    output logic               valid_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cnt
`endif
);

    fetch_state_e       state_q, state_d;
    logic               kill_q, kill_d;
    logic               req_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [INSTR_W-1:0] instr_d;
    logic [ADDR_W-1:0]  pc_out_d;
    logic               valid_d;
    logic               pc_inc;
    logic               ack_v;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_next;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc (
        .clk           (clk),
        .rst           (rst),
        .inc           (pc_inc),
        .redirect      (branch_taken),
        .redirect_addr (branch_addr),
        .pc            (pc),
        .pc_next       (pc_next)
    );

    // Acks are only meaningful against an outstanding request.
    assign ack_v = imem_ack && imem_req;

    always_comb begin
        state_d  = state_q;
        kill_d   = kill_q;
        pc_inc   = 1'b0;
        instr_d  = instruction_out;
        pc_out_d = pc_out;
        valid_d  = valid_out;
        req_d    = 1'b0;
        addr_d   = imem_addr;

        unique case (state_q)
            S_REQ: begin
                if (ack_v) begin
                    kill_d = 1'b0;
                    if (!kill_q && !branch_taken) begin
                        instr_d  = imem_rdata;
                        pc_out_d = pc + PC_STEP;
                        valid_d  = 1'b1;
                        state_d  = S_HOLD;
                    end
                end else if (branch_taken && imem_req) begin
                    // Request cannot be aborted; mark its data as stale.
                    kill_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (branch_taken || !freeze) begin
                    pc_inc  = !branch_taken;
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        // Keep an outstanding request stable; otherwise issue at the next PC.
        if (imem_req && !imem_ack) begin
            req_d  = 1'b1;
            addr_d = imem_addr;
        end else if (state_d == S_REQ) begin
            req_d  = 1'b1;
            addr_d = pc_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_REQ;
            kill_q          <= 1'b0;
            imem_req        <= 1'b0;
            imem_addr       <= '0;
            instruction_out <= NOP_INSTR;
            pc_out          <= '0;
            valid_out       <= 1'b0;
        end else begin
            state_q         <= state_d;
            kill_q          <= kill_d;
            imem_req        <= req_d;
            imem_addr       <= addr_d;
            instruction_out <= instr_d;
            pc_out          <= pc_out_d;
            valid_out       <= valid_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (!valid_out || (state_q == S_HOLD && freeze)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit with a latency-programmable memory model.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        valid_out;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] req_log[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_deliv = 0;
    bit          mem_en = 0;
    bit          mem_busy = 0;
    int          mem_lat = 1;
    logic        valid_prev = 1'b0;

    if_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .freeze          (freeze),
        .branch_taken    (branch_taken),
        .branch_addr     (branch_addr),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .valid_out       (valid_out)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt       (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hE1A0_5A00;
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] fetch_addr);
        exp_t e;
        e.pc    = fetch_addr + 32'd4;
        e.instr = mem_word(fetch_addr);
        return e;
    endfunction

    // Memory: captures a request, acks mem_lat cycles later for one cycle.
    initial begin : memory
        logic [31:0] a;
        int          lat;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        forever begin
            @(negedge clk);
            imem_ack = 1'b0;
            mem_busy = 0;
            if (mem_en && imem_req && rst) begin
                a        = imem_addr;
                lat      = mem_lat;
                mem_busy = 1;
                req_log.push_back(a);
                for (int i = 1; i < lat; i++) @(negedge clk);
                @(negedge clk);
                imem_ack   = 1'b1;
                imem_rdata = mem_word(a);
            end
        end
    end

    // Scoreboard: every new presentation must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && valid_out && !valid_prev) begin
            exp_t e;
            n_deliv++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL deliver: got pc_out=%h instr=%h, required no delivery",
                         pc_out, instruction_out);
            end else begin
                e = exp_q.pop_front();
                if (pc_out !== e.pc || instruction_out !== e.instr) begin
                    n_err++;
                    $display("FAIL deliver: got pc_out=%h instr=%h, required pc_out=%h instr=%h",
                             pc_out, instruction_out, e.pc, e.instr);
                end
            end
        end
        valid_prev = valid_out;
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset;
        mem_en       = 0;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = '0;
        for (int i = 0; i < 50 && mem_busy; i++) tick;
        #2 rst = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        req_log.delete();
        exp_q.delete();
    endtask

    task automatic test_reset;
        tick;
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b, want 0", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h, want 0", imem_addr); end
        n_cmp++; if (pc_out !== 32'h0) begin n_err++; $display("FAIL rst_pc_out: got %h, want 0", pc_out); end
        n_cmp++; if (instruction_out !== 32'h0) begin n_err++; $display("FAIL rst_instr: got %h, want 0", instruction_out); end
        n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b, want 0", valid_out); end
        rst = 1'b1;
        tick;
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL first_req: got %b, want 1", imem_req); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL first_addr: got %h, want 0", imem_addr); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL async_drop: got %b, want 0", imem_req); end
        tick;
        rst = 1'b1;
    endtask

    task automatic test_sequential;
        int          base;
        int          cycles;
        logic [31:0] got;
        do_reset;
        base = n_deliv;
        for (int k = 0; k < 3; k++) exp_q.push_back(mk_exp(32'(k * 4)));
        mem_lat = 1;
        mem_en  = 1;
        cycles  = 0;
        while (cycles < 60 && n_deliv < base + 3) begin
            tick;
            cycles++;
        end
        mem_en = 0;
        n_cmp++; if (n_deliv != base + 3) begin n_err++; $display("FAIL seq_timeout: got %0d deliveries, want 3", n_deliv - base); end
        n_cmp++; if (cycles != 9) begin n_err++; $display("FAIL seq_throughput: got %0d cycles, want 9", cycles); end
        for (int k = 0; k < 3; k++) begin
            got = 'x;
            if (req_log.size() > 0) got = req_log.pop_front();
            n_cmp++;
            if (got !== 32'(k * 4)) begin
                n_err++;
                $display("FAIL seq_req_addr%0d: got %h, want %h", k, got, 32'(k * 4));
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL seq_pending: got %0d left, want 0", exp_q.size()); end
    endtask

    task automatic test_latency;
        int base;
        do_reset;
        base = n_deliv;
        exp_q.push_back(mk_exp(32'h0));
        mem_lat = 3;
        mem_en  = 1;
        tick;
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL lat_req%0d: got %b, want 1", k, imem_req); end
            n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL lat_addr%0d: got %h, want 0", k, imem_addr); end
            n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL lat_valid%0d: got %b, want 0", k, valid_out); end
            n_cmp++; if (instruction_out !== 32'h0) begin n_err++; $display("FAIL lat_instr%0d: got %h, want 0", k, instruction_out); end
            tick;
        end
        for (int i = 0; i < 20 && n_deliv < base + 1; i++) tick;
        mem_en = 0;
        n_cmp++; if (n_deliv != base + 1) begin n_err++; $display("FAIL lat_timeout: got %0d deliveries, want 1", n_deliv - base); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL lat_pending: got %0d left, want 0", exp_q.size()); end
    endtask

    task automatic test_freeze;
        int base;
        do_reset;
        base = n_deliv;
        for (int k = 0; k < 3; k++) exp_q.push_back(mk_exp(32'(k * 4)));
        mem_lat = 1;
        mem_en  = 1;
        for (int i = 0; i < 60 && n_deliv < base + 3; i++) tick;
        freeze = 1'b1;
        mem_en = 0;
        n_cmp++; if (n_deliv != base + 3) begin n_err++; $display("FAIL frz_timeout: got %0d deliveries, want 3", n_deliv - base); end
        for (int k = 0; k < 4; k++) begin
            tick;
            n_cmp++; if (pc_out !== 32'hC) begin n_err++; $display("FAIL frz_pc%0d: got %h, want c", k, pc_out); end
            n_cmp++; if (instruction_out !== mem_word(32'h8)) begin n_err++; $display("FAIL frz_instr%0d: got %h, want %h", k, instruction_out, mem_word(32'h8)); end
            n_cmp++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL frz_valid%0d: got %b, want 1", k, valid_out); end
            n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL frz_req%0d: got %b, want 0", k, imem_req); end
        end
        freeze = 1'b0;
        tick;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin n_err++; $display("FAIL frz_next_req: got req=%b addr=%h, want req=1 addr=c", imem_req, imem_addr); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL frz_pending: got %0d left, want 0", exp_q.size()); end
    endtask

    task automatic test_branch_kill;
        int base;
        do_reset;
        base = n_deliv;
        for (int k = 0; k < 4; k++) exp_q.push_back(mk_exp(32'(k * 4)));
        mem_lat = 1;
        mem_en  = 1;
        for (int i = 0; i < 60 && n_deliv < base + 4; i++) tick;
        mem_lat = 3;
        n_cmp++; if (n_deliv != base + 4) begin n_err++; $display("FAIL kill_timeout0: got %0d deliveries, want 4", n_deliv - base); end
        tick;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_err++; $display("FAIL kill_req10: got req=%b addr=%h, want req=1 addr=10", imem_req, imem_addr); end
        tick;
        branch_taken = 1'b1;
        branch_addr  = 32'h100;
        freeze       = 1'b1;
        exp_q.push_back(mk_exp(32'h100));
        tick;
        branch_taken = 1'b0;
        freeze       = 1'b0;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_err++; $display("FAIL kill_stable: got req=%b addr=%h, want req=1 addr=10", imem_req, imem_addr); end
        tick;
        n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL kill_valid_ack: got %b, want 0", valid_out); end
        tick;
        n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL kill_valid_post: got %b, want 0", valid_out); end
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_err++; $display("FAIL kill_rereq: got req=%b addr=%h, want req=1 addr=100", imem_req, imem_addr); end
        for (int i = 0; i < 20 && n_deliv < base + 5; i++) tick;
        mem_en = 0;
        n_cmp++; if (n_deliv != base + 5) begin n_err++; $display("FAIL kill_timeout1: got %0d deliveries, want 5", n_deliv - base); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL kill_pending: got %0d left, want 0", exp_q.size()); end
    endtask

    task automatic test_branch_hold;
        int base;
        do_reset;
        base = n_deliv;
        exp_q.push_back(mk_exp(32'h0));
        mem_lat = 1;
        mem_en  = 1;
        for (int i = 0; i < 20 && n_deliv < base + 1; i++) tick;
        n_cmp++; if (n_deliv != base + 1) begin n_err++; $display("FAIL bh_timeout0: got %0d deliveries, want 1", n_deliv - base); end
        freeze       = 1'b1;
        branch_taken = 1'b1;
        branch_addr  = 32'h0000_0042;
        exp_q.push_back(mk_exp(32'h40));
        tick;
        branch_taken = 1'b0;
        freeze       = 1'b0;
        n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL bh_valid: got %b, want 0", valid_out); end
        n_cmp++; if (instruction_out !== 32'h0) begin n_err++; $display("FAIL bh_instr: got %h, want 0", instruction_out); end
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_err++; $display("FAIL bh_req: got req=%b addr=%h, want req=1 addr=40", imem_req, imem_addr); end
        for (int i = 0; i < 20 && n_deliv < base + 2; i++) tick;
        n_cmp++; if (n_deliv != base + 2) begin n_err++; $display("FAIL bh_timeout1: got %0d deliveries, want 2", n_deliv - base); end
        branch_taken = 1'b1;
        branch_addr  = 32'hFFFF_FFFC;
        exp_q.push_back(mk_exp(32'hFFFF_FFFC));
        tick;
        branch_taken = 1'b0;
        n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_req: got %h, want fffffffc", imem_addr); end
        for (int i = 0; i < 20 && n_deliv < base + 3; i++) tick;
        mem_en = 0;
        n_cmp++; if (n_deliv != base + 3) begin n_err++; $display("FAIL wrap_timeout: got %0d deliveries, want 3", n_deliv - base); end
        tick;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_next: got req=%b addr=%h, want req=1 addr=0", imem_req, imem_addr); end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bh_pending: got %0d left, want 0", exp_q.size()); end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf_cnt;
        int          base;
        int          frz_done;
        int unsigned model;
        do_reset;
        n_cmp++; if (stall_cnt !== 32'h0) begin n_err++; $display("FAIL perf_reset: got %0d, want 0", stall_cnt); end
        base = n_deliv;
        for (int k = 0; k < 3; k++) exp_q.push_back(mk_exp(32'(k * 4)));
        mem_lat  = 1;
        mem_en   = 1;
        model    = 0;
        frz_done = 0;
        for (int i = 0; i < 80 && n_deliv < base + 3; i++) begin
            if (valid_out && frz_done < 2) begin
                freeze = 1'b1;
                frz_done++;
            end else begin
                freeze = 1'b0;
            end
            if (!valid_out || freeze) model++;
            tick;
        end
        mem_en = 0;
        freeze = 1'b0;
        n_cmp++; if (stall_cnt !== model) begin n_err++; $display("FAIL perf_count: got %0d, want %0d", stall_cnt, model); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (stall_cnt !== 32'h0) begin n_err++; $display("FAIL perf_midreset: got %0d, want 0", stall_cnt); end
        tick;
        rst = 1'b1;
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL perf_pending: got %0d left, want 0", exp_q.size()); end
    endtask
`endif

    initial begin
        rst          = 1'b0;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = '0;
        test_reset;
        test_sequential;
        test_latency;
        test_freeze;
        test_branch_kill;
        test_branch_hold;
`ifdef FETCH_PERF_CNT_EN
        test_perf_cnt;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
